key_event_detect: RTL

- Multi-channel button front end: synchronises N raw key inputs, debounces each one, and emits one-cycle press and/or release pulses per channel.
- Generalises the single-key release detector with per-channel debounce, a runtime-selectable event mode and a wrapping event counter.
- Sits between the board KEY/SW pins and the synth control logic (note trigger, menu stepping).

---
 rtl/key_event_detect_if.sv | 27 ++
 rtl/key_event_detect.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/key_event_detect_if.sv
// Signal bundle for the key event front end.
// The master drives the raw keys and controls; the slave returns events and status.
interface key_event_detect_if #(
    parameter int unsigned N_KEYS  = 4,
    parameter int unsigned COUNT_W = 8,
    parameter int unsigned LAST_W  = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
);
    logic [N_KEYS-1:0]  in;
    logic [1:0]         mode;
    logic               clr_count;
    logic [N_KEYS-1:0]  press_pulse;
    logic [N_KEYS-1:0]  release_pulse;
    logic [N_KEYS-1:0]  held;
    logic               event_any;
    logic [LAST_W-1:0]  last_key;
    logic [COUNT_W-1:0] event_count;

    modport master (
        output in, mode, clr_count,
        input  press_pulse, release_pulse, held, event_any, last_key, event_count
    );

    modport slave (
        input  in, mode, clr_count,
        output press_pulse, release_pulse, held, event_any, last_key, event_count
    );
endinterface

// File: rtl/key_event_detect.sv
// Multi-channel key front end: synchronise, debounce, and emit mode-gated press/release
// pulses with a wrapping event counter and last-event channel index.
module key_event_detect #(
    parameter int unsigned N_KEYS      = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 4,
    parameter int unsigned COUNT_W     = 8
) (
    input logic               clk,
    input logic               reset,
    key_event_detect_if.slave bus
);
    localparam int unsigned LastW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
    localparam int unsigned CntW  = $clog2(DB_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StDbPress, StHeld, StDbRelease} key_state_e;

    logic [N_KEYS-1:0]  sync_q [SYNC_STAGES];
    logic [N_KEYS-1:0]  s;
    key_state_e         state_q [N_KEYS];
    key_state_e         state_d [N_KEYS];
    logic [CntW-1:0]    cnt_q [N_KEYS];
    logic [CntW-1:0]    cnt_d [N_KEYS];
    logic [N_KEYS-1:0]  press_raw, release_raw;
    logic [N_KEYS-1:0]  press_d, press_q, release_d, release_q;
    logic [N_KEYS-1:0]  held;
    logic [COUNT_W-1:0] count_d, count_q, inc;
    logic [LastW-1:0]   last_key_d, last_key_q;
    logic               press_en, release_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= bus.in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        press_raw   = '0;
        release_raw = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                StIdle: begin
                    if (s[i]) begin
                        if (DB_CYCLES == 1) begin
                            state_d[i]   = StHeld;
                            press_raw[i] = 1'b1;
                        end else begin
                            state_d[i] = StDbPress;
                            cnt_d[i]   = CntW'(1);
                        end
                    end
                end
                StDbPress: begin
                    if (!s[i]) begin
                        state_d[i] = StIdle;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CntLast) begin
                        state_d[i]   = StHeld;
                        cnt_d[i]     = '0;
                        press_raw[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CntW'(1);
                    end
                end
                StHeld: begin
                    if (!s[i]) begin
                        if (DB_CYCLES == 1) begin
                            state_d[i]     = StIdle;
                            release_raw[i] = 1'b1;
                        end else begin
                            state_d[i] = StDbRelease;
                            cnt_d[i]   = CntW'(1);
                        end
                    end
                end
                StDbRelease: begin
                    if (s[i]) begin
                        state_d[i] = StHeld;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CntLast) begin
                        state_d[i]     = StIdle;
                        cnt_d[i]       = '0;
                        release_raw[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CntW'(1);
                    end
                end
                default: begin
                    state_d[i] = StIdle;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_KEYS; i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Mode only gates what is reported; the debounce FSMs always track the keys.
    always_comb begin
        press_en   = (bus.mode == 2'd1) || (bus.mode == 2'd2);
        release_en = (bus.mode == 2'd0) || (bus.mode == 2'd2);
        press_d    = press_raw & {N_KEYS{press_en}};
        release_d  = release_raw & {N_KEYS{release_en}};
        inc        = '0;
        last_key_d = last_key_q;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            inc = inc + COUNT_W'(press_d[i] | release_d[i]);
            if (press_d[i] | release_d[i]) last_key_d = LastW'(i);
        end
        count_d = bus.clr_count ? '0 : count_q + inc;
        for (int i = 0; i < N_KEYS; i++) begin
            held[i] = (state_q[i] == StHeld) || (state_q[i] == StDbRelease);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            press_q    <= '0;
            release_q  <= '0;
            count_q    <= '0;
            last_key_q <= '0;
        end else begin
            press_q    <= press_d;
            release_q  <= release_d;
            count_q    <= count_d;
            last_key_q <= last_key_d;
        end
    end

    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.held          = held;
    assign bus.event_any     = |(press_q | release_q);
    assign bus.last_key      = last_key_q;
    assign bus.event_count   = count_q;
endmodule
